// File: rtl/me_pkg.sv
// Shared constants, types and helpers for the motion-estimation window buffer.
package me_pkg;

  localparam int unsigned MACRO_DIM  = 16;
  localparam int unsigned SEARCH_DIM = 48;
  localparam int unsigned PORT_WIDTH = MACRO_DIM + 1;
  localparam int unsigned S_GROUPS   = (SEARCH_DIM + PORT_WIDTH - 1) / PORT_WIDTH;
  localparam int unsigned S_DEPTH    = SEARCH_DIM * S_GROUPS;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned AMT_W      = 6;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned BANK_W     = 5;
  localparam int unsigned GROUP_W    = 2;
  localparam int unsigned MROW_W     = 4;
  localparam int unsigned SROW_W     = 6;

  // Column of the last search pixel in a row, expressed as bank/group.
  localparam int unsigned LAST_GROUP = (SEARCH_DIM - 1) / PORT_WIDTH;
  localparam int unsigned LAST_BANK  = (SEARCH_DIM - 1) % PORT_WIDTH;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_CUR  = 2'd1,
    LOAD_SRCH = 2'd2,
    READY     = 2'd3
  } buf_state_t;

  // Reduce a 6-bit rotation amount modulo PORT_WIDTH (at most three subtracts).
  function automatic logic [BANK_W-1:0] mod_port(input logic [AMT_W-1:0] v);
    logic [AMT_W-1:0] r;
    r = v;
    if (r >= AMT_W'(3 * PORT_WIDTH))      r = r - AMT_W'(3 * PORT_WIDTH);
    else if (r >= AMT_W'(2 * PORT_WIDTH)) r = r - AMT_W'(2 * PORT_WIDTH);
    else if (r >= AMT_W'(PORT_WIDTH))     r = r - AMT_W'(PORT_WIDTH);
    return BANK_W'(r);
  endfunction

endpackage

// File: rtl/me_window_buffer_if.sv
// Pixel stream, read port and start/done handshake between fetch, buffer and me.
interface me_window_buffer_if;
  import me_pkg::*;

  logic                          load_start;
  pixel_t                        pix_in;
  logic                          pix_valid;
  logic                          pix_ready;
  logic [ADDR_W-1:0]             addr;
  logic [AMT_W-1:0]              amt;
  pixel_t [MACRO_DIM-1:0]        pixel_cpr_out;
  pixel_t [PORT_WIDTH-1:0]       pixel_spr_out;
  logic                          me_start;
  logic                          me_done;
  logic                          buf_ready;

  // Fetch logic and me core side.
  modport master (
    output load_start, pix_in, pix_valid, addr, amt, me_done,
    input  pix_ready, pixel_cpr_out, pixel_spr_out, me_start, buf_ready
  );

  // Window buffer side.
  modport slave (
    input  load_start, pix_in, pix_valid, addr, amt, me_done,
    output pix_ready, pixel_cpr_out, pixel_spr_out, me_start, buf_ready
  );

endinterface

// File: rtl/me_bank_rotator.sv
// Combinational modulo-PORT_WIDTH rotator: lane l takes bank (l + amt) mod PORT_WIDTH.
module me_bank_rotator
  import me_pkg::*;
(
  input  pixel_t [PORT_WIDTH-1:0] words,
  input  logic   [AMT_W-1:0]      amt,
  output pixel_t [PORT_WIDTH-1:0] rotated
);

  logic [BANK_W-1:0] amt_m;

  assign amt_m = mod_port(amt);

  for (genvar g = 0; g < int'(PORT_WIDTH); g++) begin : g_lane
    logic [BANK_W:0]   idx;
    logic [BANK_W-1:0] sel;

    // idx < 2*PORT_WIDTH, so one conditional subtract wraps it.
    assign idx = (BANK_W+1)'(g) + {1'b0, amt_m};
    assign sel = (idx >= (BANK_W+1)'(PORT_WIDTH)) ? BANK_W'(idx - (BANK_W+1)'(PORT_WIDTH))
                                                  : BANK_W'(idx);
    assign rotated[g] = words[sel];
  end

endmodule

// File: rtl/me_window_buffer.sv
// Banked storage for one current macroblock and its search window, serving me's reads.
module me_window_buffer
  import me_pkg::*;
(
  input logic               clk,
  input logic               rst,
  me_window_buffer_if.slave bus
);

  buf_state_t state, state_next;

  logic pix_ready_q, pix_ready_next;
  logic me_start_q,  me_start_next;
  logic buf_ready_q, buf_ready_next;

  logic [MROW_W-1:0]  m_row, m_col;
  logic [SROW_W-1:0]  s_row;
  logic [BANK_W-1:0]  s_bank;
  logic [GROUP_W-1:0] s_group;

  logic              accept;
  logic              cur_last;
  logic              s_eol;
  logic              srch_last;
  logic [ADDR_W-1:0] s_entry;

  pixel_t c_mem [MACRO_DIM][MACRO_DIM];
  pixel_t s_mem [PORT_WIDTH][S_DEPTH];

  pixel_t [MACRO_DIM-1:0]  cpr;
  pixel_t [PORT_WIDTH-1:0] bank_words;
  pixel_t [PORT_WIDTH-1:0] spr;

  assign accept    = bus.pix_valid & pix_ready_q;
  assign cur_last  = (m_row == MROW_W'(MACRO_DIM - 1)) && (m_col == MROW_W'(MACRO_DIM - 1));
  assign s_eol     = (s_group == GROUP_W'(LAST_GROUP)) && (s_bank == BANK_W'(LAST_BANK));
  assign srch_last = (s_row == SROW_W'(SEARCH_DIM - 1)) && s_eol;

  // Entry = group*48 + row, built from shifts to avoid a multiplier.
  assign s_entry = ADDR_W'({s_group, 5'b0}) + ADDR_W'({s_group, 4'b0}) + ADDR_W'(s_row);

  // State and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pix_ready_q <= 1'b0;
      me_start_q  <= 1'b0;
      buf_ready_q <= 1'b0;
    end else begin
      state       <= state_next;
      pix_ready_q <= pix_ready_next;
      me_start_q  <= me_start_next;
      buf_ready_q <= buf_ready_next;
    end
  end

  always_comb begin
    state_next     = state;
    pix_ready_next = 1'b0;
    me_start_next  = 1'b0;
    buf_ready_next = 1'b0;
    case (state)
      IDLE:      if (bus.load_start) state_next = LOAD_CUR;
      LOAD_CUR:  if (accept && cur_last) state_next = LOAD_SRCH;
      LOAD_SRCH: if (accept && srch_last) begin
                   state_next    = READY;
                   me_start_next = 1'b1;
                 end
      READY:     if (bus.me_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    pix_ready_next = (state_next == LOAD_CUR) || (state_next == LOAD_SRCH);
    buf_ready_next = (state_next == READY);
  end

  // Raster position counters; search column is tracked as bank + group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_row   <= '0;
      m_col   <= '0;
      s_row   <= '0;
      s_bank  <= '0;
      s_group <= '0;
    end else if (state == IDLE) begin
      m_row   <= '0;
      m_col   <= '0;
      s_row   <= '0;
      s_bank  <= '0;
      s_group <= '0;
    end else if (accept && (state == LOAD_CUR)) begin
      m_col <= m_col + MROW_W'(1);
      if (m_col == MROW_W'(MACRO_DIM - 1)) m_row <= m_row + MROW_W'(1);
    end else if (accept && (state == LOAD_SRCH)) begin
      if (s_eol) begin
        s_bank  <= '0;
        s_group <= '0;
        s_row   <= (s_row == SROW_W'(SEARCH_DIM - 1)) ? '0 : s_row + SROW_W'(1);
      end else if (s_bank == BANK_W'(PORT_WIDTH - 1)) begin
        s_bank  <= '0;
        s_group <= s_group + GROUP_W'(1);
      end else begin
        s_bank  <= s_bank + BANK_W'(1);
      end
    end
  end

  // Pixel storage is not reset.
  always_ff @(posedge clk) begin
    if (accept && (state == LOAD_CUR))  c_mem[m_col][m_row]    <= bus.pix_in;
    if (accept && (state == LOAD_SRCH)) s_mem[s_bank][s_entry] <= bus.pix_in;
  end

  // Zero-latency reads; out-of-range addresses return zero.
  always_comb begin
    for (int l = 0; l < int'(MACRO_DIM); l++) begin
      cpr[l] = (bus.addr < ADDR_W'(MACRO_DIM)) ? c_mem[l][bus.addr[MROW_W-1:0]] : '0;
    end
    for (int b = 0; b < int'(PORT_WIDTH); b++) begin
      bank_words[b] = (bus.addr < ADDR_W'(S_DEPTH)) ? s_mem[b][bus.addr] : '0;
    end
  end

  me_bank_rotator u_rot (
    .words   (bank_words),
    .amt     (bus.amt),
    .rotated (spr)
  );

  assign bus.pix_ready     = pix_ready_q;
  assign bus.me_start      = me_start_q;
  assign bus.buf_ready     = buf_ready_q;
  assign bus.pixel_cpr_out = cpr;
  assign bus.pixel_spr_out = spr;

endmodule

// File: tb/tb_me_window_buffer.sv
// Directed bench for me_window_buffer: load sequencing, banked reads, rotation and control.
module tb_me_window_buffer;
  import me_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  me_window_buffer_if bus();

  me_window_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream pixel for beat k: current MB = r*16+c, then search = (r+c)&0xFF.
  function automatic pixel_t beat_pix(input int k);
    int j;
    if (k < 256) return pixel_t'(k);
    j = k - 256;
    return pixel_t'((j / 48) + (j % 48));
  endfunction

  // Expected rotated search pixel from raster geometry.
  function automatic pixel_t exp_spr(input int a, input int am, input int l);
    int b, c;
    if (a >= 144) return '0;
    b = (l + (am % 17)) % 17;
    c = (a / 48) * 17 + b;
    return pixel_t'((a % 48) + c);
  endfunction

  // Drives one load; ls_at/done_at inject a stray load_start/me_done at that beat.
  task automatic load_frame(input int pct, input int abort_at, input int ls_at, input int done_at,
                            output int acc, output int rdy, output int starts);
    int   k;
    int   guard;
    logic take;
    bit   ls_done;
    bit   dn_done;
    k = 0; guard = 0; ls_done = 0; dn_done = 0;
    acc = 0; rdy = 0; starts = 0;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    while (k < 2560 && k != abort_at && guard < 20000) begin
      bus.pix_valid  = (int'($urandom_range(99)) < pct);
      bus.pix_in     = bus.pix_valid ? beat_pix(k) : pixel_t'($urandom_range(255));
      bus.load_start = (k == ls_at) && !ls_done;
      bus.me_done    = (k == done_at) && !dn_done;
      if (bus.load_start) ls_done = 1;
      if (bus.me_done)    dn_done = 1;
      take = bus.pix_valid & bus.pix_ready;
      rdy += int'(bus.pix_ready);
      tick();
      if (take) k++;
      starts += int'(bus.me_start);
      guard++;
    end
    bus.pix_valid = 1'b0; bus.load_start = 1'b0; bus.me_done = 1'b0;
    acc = k;
    if (guard >= 20000) begin
      n_cmp++; n_err++;
      $display("FAIL load_timeout: accepted %0d beats, required 2560", k);
    end
    if (abort_at < 0) begin
      repeat (3) begin
        rdy += int'(bus.pix_ready);
        tick();
        starts += int'(bus.me_start);
      end
    end
  endtask

  task automatic test_reset();
    int spurious;
    rst = 1'b1;
    bus.load_start = 0; bus.pix_in = '0; bus.pix_valid = 0;
    bus.addr = '0; bus.amt = '0; bus.me_done = 0;
    repeat (3) tick();
    n_cmp++; if (bus.pix_ready !== 1'b0) begin n_err++; $display("FAIL reset_pix_ready: got %b want 0", bus.pix_ready); end
    n_cmp++; if (bus.me_start !== 1'b0)  begin n_err++; $display("FAIL reset_me_start: got %b want 0", bus.me_start); end
    n_cmp++; if (bus.buf_ready !== 1'b0) begin n_err++; $display("FAIL reset_buf_ready: got %b want 0", bus.buf_ready); end
    rst = 1'b0;
    tick();
    bus.load_start = 1'b1; tick(); bus.load_start = 1'b0;
    n_cmp++; if (bus.pix_ready !== 1'b1) begin n_err++; $display("FAIL load_entry_ready: got %b want 1", bus.pix_ready); end
    // Asynchronous assertion in the middle of the low phase.
    @(negedge clk); #2 rst = 1'b1; #1;
    n_cmp++; if (bus.pix_ready !== 1'b0) begin n_err++; $display("FAIL async_reset_ready: got %b want 0", bus.pix_ready); end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    spurious = 0;
    repeat (6) begin tick(); spurious += int'(bus.me_start) + int'(bus.pix_ready) + int'(bus.buf_ready); end
    n_cmp++; if (spurious !== 0) begin n_err++; $display("FAIL post_reset_quiet: got %0d active samples want 0", spurious); end
  endtask

  task automatic test_full_load();
    int acc, rdy, starts;
    load_frame(100, -1, -1, -1, acc, rdy, starts);
    n_cmp++; if (acc !== 2560)   begin n_err++; $display("FAIL full_accepted: got %0d want 2560", acc); end
    n_cmp++; if (rdy !== 2560)   begin n_err++; $display("FAIL full_ready_cycles: got %0d want 2560", rdy); end
    n_cmp++; if (starts !== 1)   begin n_err++; $display("FAIL full_me_start_pulses: got %0d want 1", starts); end
    n_cmp++; if (bus.buf_ready !== 1'b1) begin n_err++; $display("FAIL full_buf_ready: got %b want 1", bus.buf_ready); end
    n_cmp++; if (bus.pix_ready !== 1'b0) begin n_err++; $display("FAIL full_pix_ready_off: got %b want 0", bus.pix_ready); end
  endtask

  task automatic test_reads();
    pixel_t [MACRO_DIM-1:0]  e_cpr;
    pixel_t [PORT_WIDTH-1:0] e_spr;
    bus.addr = 8'd5; bus.amt = 6'd0; #1;
    for (int l = 0; l < 16; l++) e_cpr[l] = pixel_t'(80 + l);
    for (int l = 0; l < 17; l++) e_spr[l] = pixel_t'(5 + l);
    n_cmp++; if (bus.pixel_cpr_out !== e_cpr) begin n_err++; $display("FAIL cpr_addr5: got %h want %h", bus.pixel_cpr_out, e_cpr); end
    n_cmp++; if (bus.pixel_spr_out !== e_spr) begin n_err++; $display("FAIL spr_addr5: got %h want %h", bus.pixel_spr_out, e_spr); end
    bus.addr = 8'd15; #1;
    for (int l = 0; l < 16; l++) e_cpr[l] = pixel_t'(240 + l);
    n_cmp++; if (bus.pixel_cpr_out !== e_cpr) begin n_err++; $display("FAIL cpr_addr15: got %h want %h", bus.pixel_cpr_out, e_cpr); end
    bus.addr = 8'd16; #1;
    n_cmp++; if (bus.pixel_cpr_out !== '0) begin n_err++; $display("FAIL cpr_addr16_zero: got %h want 0", bus.pixel_cpr_out); end
    bus.addr = 8'd95; #1;
    for (int l = 0; l < 17; l++) e_spr[l] = exp_spr(95, 0, l);
    n_cmp++; if (bus.pixel_spr_out !== e_spr) begin n_err++; $display("FAIL spr_addr95: got %h want %h", bus.pixel_spr_out, e_spr); end
  endtask

  task automatic test_rotated(input string tag);
    pixel_t [PORT_WIDTH-1:0] e_spr;
    pixel_t [MACRO_DIM-1:0]  e_cpr;
    bus.addr = 8'd53; bus.amt = 6'd3; #1;
    n_cmp++; if (bus.pixel_spr_out[0] !== 8'd25)  begin n_err++; $display("FAIL %s spr53_lane0: got %0d want 25", tag, bus.pixel_spr_out[0]); end
    n_cmp++; if (bus.pixel_spr_out[14] !== 8'd22) begin n_err++; $display("FAIL %s spr53_lane14: got %0d want 22", tag, bus.pixel_spr_out[14]); end
    for (int l = 0; l < 17; l++) e_spr[l] = pixel_t'(22 + ((l + 3) % 17));
    n_cmp++; if (bus.pixel_spr_out !== e_spr) begin n_err++; $display("FAIL %s spr53_amt3: got %h want %h", tag, bus.pixel_spr_out, e_spr); end
    bus.amt = 6'd20; #1;
    n_cmp++; if (bus.pixel_spr_out !== e_spr) begin n_err++; $display("FAIL %s spr53_amt20: got %h want %h", tag, bus.pixel_spr_out, e_spr); end
    bus.addr = 8'd60; bus.amt = 6'd63; #1;
    for (int l = 0; l < 17; l++) e_spr[l] = exp_spr(60, 63, l);
    n_cmp++; if (bus.pixel_spr_out !== e_spr) begin n_err++; $display("FAIL %s spr60_amt63: got %h want %h", tag, bus.pixel_spr_out, e_spr); end
    bus.addr = 8'd144; bus.amt = 6'd0; #1;
    n_cmp++; if (bus.pixel_spr_out !== '0) begin n_err++; $display("FAIL %s spr144_zero: got %h want 0", tag, bus.pixel_spr_out); end
    bus.addr = 8'd143; #1;
    for (int l = 0; l < 17; l++) e_spr[l] = (l < 14) ? exp_spr(143, 0, l) : bus.pixel_spr_out[l];
    n_cmp++; if (bus.pixel_spr_out[13:0] !== e_spr[13:0]) begin n_err++; $display("FAIL %s spr143_last_row: got %h want %h", tag, bus.pixel_spr_out[13:0], e_spr[13:0]); end
    bus.addr = 8'd0; #1;
    for (int l = 0; l < 16; l++) e_cpr[l] = pixel_t'(l);
    n_cmp++; if (bus.pixel_cpr_out !== e_cpr) begin n_err++; $display("FAIL %s cpr_addr0: got %h want %h", tag, bus.pixel_cpr_out, e_cpr); end
  endtask

  task automatic test_me_done();
    bus.me_done = 1'b1; tick(); bus.me_done = 1'b0;
    n_cmp++; if (bus.buf_ready !== 1'b0) begin n_err++; $display("FAIL done_buf_ready: got %b want 0", bus.buf_ready); end
    n_cmp++; if (bus.me_start !== 1'b0)  begin n_err++; $display("FAIL done_me_start: got %b want 0", bus.me_start); end
    // Stray me_done in IDLE must not disturb anything.
    bus.me_done = 1'b1; tick(); bus.me_done = 1'b0; tick();
    n_cmp++; if (bus.pix_ready !== 1'b0 || bus.buf_ready !== 1'b0) begin
      n_err++; $display("FAIL idle_stray_done: got ready=%b buf=%b want 0 0", bus.pix_ready, bus.buf_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    int acc, rdy, starts;
    load_frame(100, 1000, -1, -1, acc, rdy, starts);
    n_cmp++; if (acc !== 1000) begin n_err++; $display("FAIL abort_point: got %0d want 1000", acc); end
    rst = 1'b1; #1;
    n_cmp++; if (bus.pix_ready !== 1'b0) begin n_err++; $display("FAIL midload_reset_ready: got %b want 0", bus.pix_ready); end
    tick(); tick();
    rst = 1'b0; tick();
    load_frame(100, -1, -1, -1, acc, rdy, starts);
    n_cmp++; if (rdy !== 2560)  begin n_err++; $display("FAIL reload_ready_cycles: got %0d want 2560", rdy); end
    n_cmp++; if (starts !== 1)  begin n_err++; $display("FAIL reload_me_start_pulses: got %0d want 1", starts); end
    test_rotated("reload");
    test_me_done();
  endtask

  task automatic test_back_to_back();
    int acc, rdy, starts;
    // 50% valid, stray load_start in LOAD_SRCH and stray me_done in LOAD_SRCH.
    load_frame(50, -1, 500, 300, acc, rdy, starts);
    n_cmp++; if (acc !== 2560)  begin n_err++; $display("FAIL bp_accepted: got %0d want 2560", acc); end
    n_cmp++; if (starts !== 1)  begin n_err++; $display("FAIL bp_me_start_pulses: got %0d want 1", starts); end
    n_cmp++; if (bus.buf_ready !== 1'b1) begin n_err++; $display("FAIL bp_buf_ready: got %b want 1", bus.buf_ready); end
    test_reads();
    test_rotated("bp");
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_reads();
    test_rotated("first");
    test_me_done();
    test_reset_mid_load();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/me_window_buffer.md
Name: me_window_buffer

Overview:
- Memory-side responder for the motion-estimation core `me`.
- Accepts a raster pixel stream and stores it in two banked buffers: first the 16x16 current macroblock, then the 48x48 search window.
- Serves `me`'s addr/amt read requests: column-banked current-MB pixels, and search-window pixels rotated across PORT_WIDTH banks.
- Sits between the frame fetch logic and `me`. It generates `me`'s start pulse and releases the window on `me`'s done.

Parameters:
- MACRO_DIM, 16, macroblock edge in pixels.
- SEARCH_DIM, 48, search-window edge in pixels.
- PORT_WIDTH, MACRO_DIM+1, number of search banks (17).
- S_DEPTH, SEARCH_DIM*((SEARCH_DIM+PORT_WIDTH-1)/PORT_WIDTH), entries per search bank (144).
- ADDR_W, 8, read address width; must satisfy 2^ADDR_W >= S_DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- load_start  in  1  pulse: begin loading a new MB and window
- pix_in  in  8  stream pixel
- pix_valid  in  1  stream beat valid
- pix_ready  out  1  stream beat accepted when valid&ready
- addr  in  ADDR_W  read address from `me`
- amt  in  6  bank rotation amount from `me`
- pixel_cpr_out  out  8 x MACRO_DIM  current-MB column pixels
- pixel_spr_out  out  8 x PORT_WIDTH  rotated search pixels
- me_start  out  1  one-cycle start pulse to `me`
- me_done  in  1  `me` finished; release buffer
- buf_ready  out  1  buffer holds a complete, stable window

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, pix_ready=0, me_start=0, buf_ready=0, all counters 0. Storage contents are not cleared.
- FSM states: IDLE, LOAD_CUR, LOAD_SRCH, READY.
- IDLE -> LOAD_CUR on load_start.
- LOAD_CUR -> LOAD_SRCH after accepting MACRO_DIM^2 beats.
- LOAD_SRCH -> READY after accepting SEARCH_DIM^2 beats. The transition cycle registers me_start=1 for exactly one cycle and buf_ready=1.
- READY -> IDLE on me_done; buf_ready drops the next cycle.
- pix_ready=1 exactly in LOAD_CUR and LOAD_SRCH. Only beats with pix_valid&pix_ready advance the counters; bubbles are legal.
- load_start outside IDLE is ignored. me_done outside READY is ignored.
- Current-MB write, raster (r,c): c_bank[c][r] = pixel.
- Search write, raster (r,c): bank = c mod PORT_WIDTH, entry = (c div PORT_WIDTH)*SEARCH_DIM + r. This is tracked with a bank counter (0..16, wrap) and a group counter (0..2), both cleared at end of row. No divider is used.
- Reads are combinational, zero latency; `me` samples the outputs at its next edge.
- pixel_cpr_out[l] = c_bank[l][addr]. When addr >= MACRO_DIM, the output is 0.
- pixel_spr_out[l] = s_bank[(l + amt') mod PORT_WIDTH][addr], where amt' = amt mod PORT_WIDTH. Because l + amt' < 2*PORT_WIDTH, a single conditional subtract suffices. When addr >= S_DEPTH, the output is 0.
- Reads in states other than READY return current storage contents. They are legal but not guaranteed meaningful.
- Reset mid-load: the FSM returns to IDLE immediately and the partial load is discarded logically. A new load_start restarts from pixel 0.

Decomposition:
- Package me_pkg:
  - MACRO_DIM, SEARCH_DIM, PORT_WIDTH, S_DEPTH constants
  - pixel_t (logic [7:0])
  - buf_state_t enum
  - mod_port() helper function
- Sub-module me_bank_rotator: combinational modulo-PORT_WIDTH barrel rotator. Inputs are the PORT_WIDTH bank read words and amt; output is pixel_spr_out.

Test Plan:
- Reset: assert rst for 3 cycles mid-clock -> pix_ready=0, me_start=0, buf_ready=0 asynchronously; no spurious me_start after release.
- Full load: current pixel = r*16+c, search pixel = (r+c)&0xFF, pix_valid held high -> pix_ready high for exactly 2560 cycles; me_start is a single 1-cycle pulse; buf_ready=1.
- Reads, amt=0 and addr=5 -> pixel_cpr_out[l] = 80+l and pixel_spr_out[l] = 5+l.
- Reads, rotated: addr=53 (group 1, row 5), amt=3 -> pixel_spr_out[l] = 5+17+((l+3) mod 17), e.g. pixel_spr_out[0]=25, pixel_spr_out[14]=22.
- Backpressure and wrap: pix_valid random at 50% -> still exactly 2560 accepted beats, identical read results. amt=20 matches amt=3. addr=144 gives all-zero pixel_spr_out.
- Control:
  - load_start pulsed during LOAD_SRCH -> ignored.
  - me_done in READY -> buf_ready=0, state IDLE.
  - rst asserted at beat 1000, then a fresh full load -> correct data and one me_start.
